// File: rtl/eth_tx_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_tx_arb : round-robin frame arbiter/sequencer feeding the eth_tx FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module eth_tx_arb #(
  parameter int pNUM_REQ     = 2,
  parameter int pMIN_PAYLOAD = 46,
  parameter int pMAX_PAYLOAD = 256,
  parameter int pIFG_CYCLES  = 48
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [pNUM_REQ-1:0]   Req,
  input  logic [8*pNUM_REQ-1:0] Req_Byte,
  input  logic [pNUM_REQ-1:0]   Req_Byte_Valid,
  input  logic [pNUM_REQ-1:0]   Req_Last,
  output logic [pNUM_REQ-1:0]   Grant,
  output logic [7:0]            Eth_Byte,
  output logic                  Eth_Byte_Valid,
  output logic                  Eth_Pkt_Rdy,
  input  logic                  Tx_En,
  output logic                  Busy,
  output logic                  Err_Oversize
);
  localparam int c_PW = $clog2(pNUM_REQ);
  localparam int c_CW = $clog2(pMAX_PAYLOAD + 1);
  localparam int c_IW = $clog2(pIFG_CYCLES + 1);
  localparam logic [c_CW-1:0] c_MIN      = c_CW'(pMIN_PAYLOAD);
  localparam logic [c_CW-1:0] c_MAX      = c_CW'(pMAX_PAYLOAD);
  localparam logic [c_IW-1:0] c_IFG_LAST = c_IW'(pIFG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    PAD        = 3'd2,
    LAUNCH     = 3'd3,
    WAIT_START = 3'd4,
    WAIT_END   = 3'd5,
    IFG        = 3'd6
  } state_t;

  state_t          r_state;
  logic [c_PW-1:0] r_ptr;
  logic [c_CW-1:0] r_count;
  logic [c_IW-1:0] r_ifgCnt;
  logic            r_ovfSeen;

  logic [c_PW-1:0] w_win;
  logic [c_PW-1:0] w_nextPtr;
  logic [7:0]      w_byte;
  logic            w_accept;
  logic            w_last;
  logic            w_room;
  logic [c_CW-1:0] w_countAfter;
  int              w_idx;

  // Scan from the farthest offset down so the requester closest to the pointer wins.
  always_comb begin
    w_win = r_ptr;
    w_idx = 0;
    for (int k = pNUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= pNUM_REQ) w_idx = w_idx - pNUM_REQ;
      if (Req[w_idx]) w_win = c_PW'(w_idx);
    end
    if (int'(w_win) == pNUM_REQ - 1) w_nextPtr = '0;
    else                             w_nextPtr = w_win + 1'b1;
  end

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < pNUM_REQ; i++) begin
      if (Grant[i]) w_byte = Req_Byte[8*i +: 8];
    end
  end

  assign w_accept     = (r_state == LOAD) && |(Grant & Req_Byte_Valid);
  assign w_last       = |(Grant & Req_Last);
  assign w_room       = (r_count < c_MAX);
  assign w_countAfter = w_room ? r_count + 1'b1 : r_count;
  assign Busy         = (r_state != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_count        <= '0;
      r_ifgCnt       <= '0;
      r_ovfSeen      <= 1'b0;
      Grant          <= '0;
      Eth_Byte       <= 8'h00;
      Eth_Byte_Valid <= 1'b0;
      Eth_Pkt_Rdy    <= 1'b0;
      Err_Oversize   <= 1'b0;
    end else begin
      Eth_Byte_Valid <= 1'b0;
      Eth_Pkt_Rdy    <= 1'b0;
      Err_Oversize   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_count   <= '0;
          r_ovfSeen <= 1'b0;
          if (|Req) begin
            Grant   <= pNUM_REQ'(1) << w_win;
            r_ptr   <= w_nextPtr;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_accept) begin
            // Past the FIFO depth bytes are swallowed; only the first one is flagged.
            if (w_room) begin
              Eth_Byte       <= w_byte;
              Eth_Byte_Valid <= 1'b1;
              r_count        <= w_countAfter;
            end else if (!r_ovfSeen) begin
              Err_Oversize <= 1'b1;
              r_ovfSeen    <= 1'b1;
            end
            if (w_last) begin
              Grant   <= '0;
              r_state <= (w_countAfter < c_MIN) ? PAD : LAUNCH;
            end
          end
        end
        PAD: begin
          Eth_Byte       <= 8'h00;
          Eth_Byte_Valid <= 1'b1;
          r_count        <= w_countAfter;
          if (w_countAfter >= c_MIN) r_state <= LAUNCH;
        end
        LAUNCH: begin
          Eth_Pkt_Rdy <= 1'b1;
          r_state     <= WAIT_START;
        end
        WAIT_START: begin
          if (Tx_En) r_state <= WAIT_END;
        end
        WAIT_END: begin
          // The cycle Tx_En is first seen low counts as the first gap cycle.
          if (!Tx_En) begin
            r_ifgCnt <= c_IW'(1);
            r_state  <= IFG;
          end
        end
        IFG: begin
          r_ifgCnt <= r_ifgCnt + 1'b1;
          if (r_ifgCnt >= c_IFG_LAST) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`default_nettype none
// Bench for eth_tx_arb: vector table, directed reset/round-robin sequences and random
// frames checked against a frame-level model (expected FIFO contents, grant order, timing).
module tb_eth_tx_arb;
  localparam int N    = 2;
  localparam int MINP = 46;
  localparam int MAXP = 256;
  localparam int IFG  = 48;

  logic           Clk = 1'b0;
  logic           Rst;
  logic [N-1:0]   Req;
  logic [8*N-1:0] Req_Byte;
  logic [N-1:0]   Req_Byte_Valid;
  logic [N-1:0]   Req_Last;
  logic [N-1:0]   Grant;
  logic [7:0]     Eth_Byte;
  logic           Eth_Byte_Valid;
  logic           Eth_Pkt_Rdy;
  logic           Tx_En;
  logic           Busy;
  logic           Err_Oversize;

  eth_tx_arb #(
    .pNUM_REQ(N), .pMIN_PAYLOAD(MINP), .pMAX_PAYLOAD(MAXP), .pIFG_CYCLES(IFG)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Req_Byte(Req_Byte),
    .Req_Byte_Valid(Req_Byte_Valid), .Req_Last(Req_Last), .Grant(Grant),
    .Eth_Byte(Eth_Byte), .Eth_Byte_Valid(Eth_Byte_Valid), .Eth_Pkt_Rdy(Eth_Pkt_Rdy),
    .Tx_En(Tx_En), .Busy(Busy), .Err_Oversize(Err_Oversize)
  );

  always #5 Clk = ~Clk;

  int nVec  = 0;
  int nFail = 0;
  int cyc   = 0;
  int rrPtr = 0;
  int ohViol = 0;
  logic [7:0] outQ[$];
  int wrCycQ[$];
  int pktCycQ[$];
  int errCycQ[$];

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Passive recorder; the driver only reads these from per-frame base indices.
  initial forever begin
    @(negedge Clk);
    if (Eth_Byte_Valid) begin
      outQ.push_back(Eth_Byte);
      wrCycQ.push_back(cyc);
    end
    if (Eth_Pkt_Rdy)  pktCycQ.push_back(cyc);
    if (Err_Oversize) errCycQ.push_back(cyc);
    if ($countones(Grant) > 1) ohViol++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [7:0] gen_byte(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'hA5;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, Grant, 0);
    check({tag, "_eth_byte"}, Eth_Byte, 0);
    check({tag, "_byte_valid"}, Eth_Byte_Valid, 0);
    check({tag, "_pkt_rdy"}, Eth_Pkt_Rdy, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_err_oversize"}, Err_Oversize, 0);
  endtask

  task automatic reset_dut();
    Rst = 1'b1; Req = '0; Req_Byte = '0; Req_Byte_Valid = '0; Req_Last = '0; Tx_En = 1'b0;
    tick();
    Rst = 1'b0;
    rrPtr = 0;
  endtask

  task automatic wait_grant(output int win);
    win = -1;
    for (int t = 0; t < 60; t++) begin
      if (Grant != '0) begin
        for (int i = N - 1; i >= 0; i--) if (Grant[i]) win = i;
        return;
      end
      tick();
    end
  endtask

  task automatic run_frame(input logic [N-1:0] reqBits, input bit holdReq, input int len,
                           input int mode, input bit gaps, input bit dropReq,
                           input int expWrites, input bit expErr);
    logic [7:0] data[$];
    logic [7:0] expQ[$];
    int expWin, win, o, i, k, b0, pb, eb, ob, firstAcc, lastAcc, accOvf, mism;
    int firstWr, lastWr, expPkt;
    for (i = 0; i < len; i++) data.push_back(gen_byte(mode, i));
    for (i = 0; i < len && i < MAXP; i++) expQ.push_back(data[i]);
    while (expQ.size() < MINP) expQ.push_back(8'h00);
    expWin = rr_pick(reqBits, rrPtr);
    b0 = outQ.size(); pb = pktCycQ.size(); eb = errCycQ.size(); ob = ohViol;

    Req = reqBits;
    wait_grant(win);
    if (win < 0) begin
      check("grant_timeout", 0, 1);
      reset_dut();
      return;
    end
    check("grant_idx", win, expWin);
    check("grant_onehot", $countones(Grant), 1);
    check("busy_load", Busy, 1);
    rrPtr = (expWin + 1) % N;
    o = (win + 1) % N;
    if (dropReq && !holdReq) Req = '0;

    i = 0; firstAcc = -1; lastAcc = -1; accOvf = -1;
    while (i < len) begin
      Req_Byte_Valid[o] = 1'($urandom);
      Req_Last[o]       = 1'($urandom);
      Req_Byte[8*o +: 8] = 8'($urandom);
      if (gaps && ($urandom % 3 == 0)) begin
        Req_Byte_Valid[win]  = 1'b0;
        Req_Last[win]        = 1'($urandom);
        Req_Byte[8*win +: 8] = 8'($urandom);
      end else begin
        Req_Byte_Valid[win]  = 1'b1;
        Req_Last[win]        = (i == len - 1);
        Req_Byte[8*win +: 8] = data[i];
        if (i == 0)       firstAcc = cyc;
        if (i == MAXP)    accOvf   = cyc;
        if (i == len - 1) lastAcc  = cyc;
        i++;
      end
      tick();
    end
    Req_Byte_Valid = '0; Req_Last = '0; Req_Byte = '0;
    if (!holdReq) Req = '0;
    check("grant_drop", Grant, 0);

    for (k = 0; k < 80 && pktCycQ.size() == pb; k++) tick();
    if (pktCycQ.size() == pb) begin
      check("pkt_timeout", 0, 1);
      reset_dut();
      return;
    end
    repeat ($urandom_range(1, 20)) tick();
    check("busy_wait_start", Busy, 1);
    Tx_En = 1'b1;
    repeat ($urandom_range(3, 30)) tick();
    Tx_En = 1'b0;
    for (k = 1; k <= 200; k++) begin
      tick();
      if (!Busy) break;
    end
    check("ifg_gap", k, IFG);

    check("write_count", outQ.size() - b0, expWrites);
    mism = 0;
    for (i = 0; i < expQ.size(); i++)
      if (b0 + i >= outQ.size() || outQ[b0 + i] !== expQ[i]) mism++;
    check("payload_bad_bytes", mism, 0);
    check("pkt_count", pktCycQ.size() - pb, 1);
    firstWr = (outQ.size() > b0) ? wrCycQ[b0] : -1;
    lastWr  = (outQ.size() > b0) ? wrCycQ[wrCycQ.size() - 1] : -1;
    expPkt  = (lastAcc + 2 > lastWr + 1) ? lastAcc + 2 : lastWr + 1;
    check("pkt_timing", pktCycQ[pb], expPkt);
    check("first_latency", firstWr, firstAcc + 1);
    check("err_count", errCycQ.size() - eb, expErr);
    if (expErr) check("err_timing", (errCycQ.size() > eb) ? errCycQ[eb] : -1, accOvf + 1);
    check("grant_onehot_run", ohViol - ob, 0);
  endtask

  typedef struct {
    int src;
    int len;
    int mode;
    bit gaps;
    int expWrites;
    bit expErr;
  } vec_t;

  vec_t tbl[9];
  logic [N-1:0] rb;
  int len, ew, w, pb0, b0;

  initial begin
    tbl[0] = '{0,  60, 0, 1'b0,  60, 1'b0};
    tbl[1] = '{1,  10, 1, 1'b0,  46, 1'b0};
    tbl[2] = '{0, 300, 0, 1'b0, 256, 1'b1};
    tbl[3] = '{1,  45, 2, 1'b1,  46, 1'b0};
    tbl[4] = '{0,  46, 2, 1'b1,  46, 1'b0};
    tbl[5] = '{1,  47, 2, 1'b1,  47, 1'b0};
    tbl[6] = '{0, 256, 2, 1'b1, 256, 1'b0};
    tbl[7] = '{1, 257, 2, 1'b1, 256, 1'b1};
    tbl[8] = '{0,   1, 0, 1'b0,  46, 1'b0};

    Rst = 1'b1; Req = '0; Req_Byte = '0; Req_Byte_Valid = '0; Req_Last = '0; Tx_En = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    Rst = 1'b0;
    tick();

    // Both sources requesting continuously: grants must alternate from pointer 0.
    run_frame(2'b11, 1'b1, 50, 2, 1'b0, 1'b0, 50, 1'b0);
    run_frame(2'b11, 1'b1, 20, 1, 1'b1, 1'b0, 46, 1'b0);
    run_frame(2'b11, 1'b0, 70, 0, 1'b0, 1'b0, 70, 1'b0);

    for (int v = 0; v < 9; v++) begin
      rb = '0;
      rb[tbl[v].src] = 1'b1;
      run_frame(rb, 1'b0, tbl[v].len, tbl[v].mode, tbl[v].gaps, 1'b0,
                tbl[v].expWrites, tbl[v].expErr);
    end

    // Reset in the middle of a source-0 load, then contend: source 0 must win again.
    pb0 = pktCycQ.size(); b0 = outQ.size();
    Req = 2'b01;
    wait_grant(w);
    check("rst_seq_grant", w, rr_pick(2'b01, rrPtr));
    for (int i = 0; i < 20; i++) begin
      Req_Byte_Valid[0] = 1'b1;
      Req_Byte[7:0] = 8'(i + 1);
      tick();
    end
    Rst = 1'b1; Req_Byte_Valid = '0; Req_Byte = '0;
    tick();
    check_reset_outputs("midload_reset");
    Rst = 1'b0; Req = '0; rrPtr = 0;
    repeat (30) tick();
    check("midload_no_pkt", pktCycQ.size() - pb0, 0);
    check("midload_partial_writes", outQ.size() - b0, 20);
    run_frame(2'b11, 1'b0, 50, 0, 1'b1, 1'b0, 50, 1'b0);

    for (int r = 0; r < 10; r++) begin
      rb  = N'($urandom_range(1, (1 << N) - 1));
      len = ($urandom % 2 == 0) ? $urandom_range(1, 70) : $urandom_range(230, 300);
      ew  = (len > MAXP) ? MAXP : len;
      if (ew < MINP) ew = MINP;
      run_frame(rb, 1'b0, len, 2, 1'($urandom), 1'($urandom), ew, len > MAXP);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/eth_tx_arb.md
# eth_tx_arb

Transmit-side frame arbiter and sequencer in front of `eth_tx`. It shares the single RMII transmit datapath between `pNUM_REQ` packet sources using round-robin arbitration. It streams the granted source's payload into the `eth_tx` payload FIFO, zero-pads short payloads, truncates oversize ones and pulses `Eth_Pkt_Rdy` to launch the frame. It then tracks `Tx_En` and enforces the inter-frame gap before granting again.

## Interface
Parameters:
- `pNUM_REQ`, default 2: number of requesters, legal range 2..4.
- `pMIN_PAYLOAD`, default 46: minimum payload bytes. Shorter frames are zero-padded.
- `pMAX_PAYLOAD`, default 256: maximum payload bytes. Equals the downstream FIFO depth.
- `pIFG_CYCLES`, default 48: idle Clk cycles after `Tx_En` falls. This is 12 byte times at 2 bits per cycle.

Ports:
- `Clk` in, 1: clock.
- `Rst` in, 1: reset, synchronous, active-high.
- `Req` in, `pNUM_REQ`: per-source frame request (level).
- `Req_Byte` in, `8*pNUM_REQ`: per-source payload byte. Source i drives bits [8i+7:8i].
- `Req_Byte_Valid` in, `pNUM_REQ`: per-source byte valid.
- `Req_Last` in, `pNUM_REQ`: qualifies a valid byte as the final payload byte.
- `Grant` out, `pNUM_REQ`: one-hot grant, registered.
- `Eth_Byte` out, 8: byte to the `eth_tx` FIFO.
- `Eth_Byte_Valid` out, 1: FIFO write strobe.
- `Eth_Pkt_Rdy` out, 1: one-cycle frame launch pulse.
- `Tx_En` in, 1: transmit enable from `eth_tx`.
- `Busy` out, 1: high whenever the state is not IDLE.
- `Err_Oversize` out, 1: one-cycle pulse when a frame is truncated.

## Operation
- States and transitions:
  - IDLE → LOAD when any `Req` bit is high. The winner is chosen round-robin and its `Grant` bit is set.
  - LOAD → PAD when an accepted byte has `Req_Last` set and the byte count after it is less than `pMIN_PAYLOAD`.
  - LOAD → LAUNCH when `Req_Last` is accepted and the count is at least `pMIN_PAYLOAD`.
  - PAD → LAUNCH when the count reaches `pMIN_PAYLOAD`.
  - LAUNCH → WAIT_START, always.
  - WAIT_START → WAIT_END when `Tx_En` = 1.
  - WAIT_END → IFG when `Tx_En` = 0.
  - IFG → IDLE after `pIFG_CYCLES` cycles.
- Round robin:
  - The priority pointer resets to 0.
  - The search starts at the pointer and proceeds upward with wrap-around.
  - After granting source i, the pointer becomes (i+1) mod `pNUM_REQ`.
- `Grant` is high only in LOAD. It drops on the cycle after the `Req_Last` byte is accepted.
- A byte is accepted when the state is LOAD, `Grant[i]` = 1 and `Req_Byte_Valid[i]` = 1 in the same cycle. Non-granted sources' inputs are ignored.
- `Req_Last` without `Req_Byte_Valid` is ignored. Deasserting `Req` while granted does not end the frame; only an accepted `Req_Last` does.
- Byte counter:
  - Width is clog2(`pMAX_PAYLOAD`+1).
  - Cleared in IDLE.
  - Incremented on every forwarded byte, whether source byte or pad byte.
- PAD writes `Eth_Byte` = 0x00 with `Eth_Byte_Valid` = 1 on every cycle.
- Oversize handling:
  - Once the count equals `pMAX_PAYLOAD`, further accepted bytes are consumed but not forwarded.
  - `Err_Oversize` pulses once, on the first discarded byte.
  - The frame is still launched when `Req_Last` arrives.
- Reset mid-operation:
  - The state returns to IDLE and the pointer to 0.
  - The downstream FIFO is cleared by the same `Rst`.
  - The partial frame is lost and no `Eth_Pkt_Rdy` is issued.
- Reset values: `Grant` = 0, `Eth_Byte` = 0x00, `Eth_Byte_Valid` = 0, `Eth_Pkt_Rdy` = 0, `Busy` = 0, `Err_Oversize` = 0.

## Timing
- Arbitration: `Req` is sampled in IDLE at cycle N, and `Grant` is high at N+1. The earliest byte acceptance is N+1.
- Forwarding: a byte accepted at cycle T appears on `Eth_Byte` with `Eth_Byte_Valid` = 1 at T+1. Back-to-back bytes are sustained at one per cycle.
- PAD: the first pad byte is driven on the cycle after the last source byte is driven.
- Launch: `Eth_Pkt_Rdy` is high for exactly one cycle, the cycle after the final FIFO write (source or pad).
- WAIT_START has no timeout. `Tx_En` must rise before the next grant is possible.
- Gap: the IFG counter starts on the first cycle `Tx_En` is observed low in WAIT_END. `Busy` falls after exactly `pIFG_CYCLES` IFG cycles.
- Minimum request-to-request spacing: a frame's `Req_Last` acceptance to the next `Grant` is never shorter than launch + transmit + `pIFG_CYCLES` + 1.

## Test plan
- Single frame: source 0 sends 60 bytes 0x00..0x3B. Expect 60 writes in order at 1-cycle latency, one `Eth_Pkt_Rdy` pulse, and `Busy` low exactly 48 cycles after `Tx_En` falls.
- Short frame: source 1 sends 10 bytes of 0xA5. Expect 10 × 0xA5 followed by 36 × 0x00 (46 writes total), then `Eth_Pkt_Rdy`.
- Round robin: `Req` = 2'b11 held for three frames. Expect grants 0, 1, 0, and each `Grant` stays one-hot.
- Oversize: source 0 sends 300 bytes. Expect exactly 256 writes, one `Err_Oversize` pulse on byte 257, and launch after byte 300.
- Reset mid-LOAD: `Rst` asserted after 20 bytes. Expect all outputs at reset values next cycle, no `Eth_Pkt_Rdy`, and the next grant goes to source 0.
- Non-granted noise: source 1 toggles `Req_Byte_Valid` while source 0 is granted. Expect no source-1 bytes forwarded.
